// File: rtl/check_node_minsum_serial.sv
// Serial min-sum LDPC check node: collects DEG LLRs, then emits DEG extrinsic messages one per out handshake.
// Output valid 1 cycle after last input; in_ready low while emitting, outputs hold under out_ready stall; CNODE_HALF_SCALE_EN halves output magnitudes.
module check_node_minsum_serial #(
  parameter int DEG = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
);

  localparam int CW = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [30:0]   MAG_INF  = 31'h7F80_0000;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEG - 1);

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx1_q, idx1_d;
  logic [30:0]      min1_q, min1_d;
  logic [30:0]      min2_q, min2_d;
  logic             parity_q, parity_d;
  logic [DEG-1:0]   sign_q, sign_d;

  logic        in_fire;
  logic        out_fire;
  logic [30:0] in_mag;
  logic [30:0] sel_mag;
  logic [30:0] out_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx1_d   = idx1_q;
    min1_d   = min1_q;
    min2_d   = min2_q;
    parity_d = parity_q;
    sign_d   = sign_q;

    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == EMIT);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    in_mag    = in_data[30:0];

    case (state_q)
      COLLECT: begin
        if (in_fire) begin
          sign_d[cnt_q] = in_data[31];
          parity_d      = parity_q ^ in_data[31];
          // Strict compare: an equal magnitude never displaces the earlier min1.
          if (in_mag < min1_q) begin
            min2_d = min1_q;
            min1_d = in_mag;
            idx1_d = cnt_q;
          end else if (in_mag < min2_q) begin
            min2_d = in_mag;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = EMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            state_d  = COLLECT;
            min1_d   = MAG_INF;
            min2_d   = MAG_INF;
            idx1_d   = '0;
            parity_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    // Each edge gets the minimum over the other edges: min2 for the minimum's own edge.
    sel_mag = (cnt_q == idx1_q) ? min2_q : min1_q;
`ifdef CNODE_HALF_SCALE_EN
    if (sel_mag[30:23] == 8'hFF) begin
      out_mag = sel_mag;
    end else if (sel_mag[30:23] <= 8'd1) begin
      out_mag = '0;
    end else begin
      out_mag = {sel_mag[30:23] - 8'd1, sel_mag[22:0]};
    end
`else
    out_mag = sel_mag;
`endif
    out_data = out_valid ? {parity_q ^ sign_q[cnt_q], out_mag} : 32'h0;
    out_last = out_valid && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      idx1_q   <= '0;
      min1_q   <= MAG_INF;
      min2_q   <= MAG_INF;
      parity_q <= 1'b0;
      sign_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx1_q   <= idx1_d;
      min1_q   <= min1_d;
      min2_q   <= min2_d;
      parity_q <= parity_d;
      sign_q   <= sign_d;
    end
  end

endmodule
